// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles every handshake and datapath signal of the shared-ALU arbiter.
//   req0_* / req1_*   : request channel (valid/ready, two operands, ALU ctrl)
//   rsp0_* / rsp1_*   : response channel (valid/ready per requester)
//   rsp_result/zero   : shared registered result bus, qualified by rspN_valid
//   flush0            : kills all in-flight requester-0 work
//   alu_*             : operand/control out to the ALU, result/zero back
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the ALU)
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_op1;
    logic [DATA_W-1:0] req0_op2;
    logic [CTRL_W-1:0] req0_ctrl;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_op1;
    logic [DATA_W-1:0] req1_op2;
    logic [CTRL_W-1:0] req1_ctrl;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              flush0;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_operand2;
    logic [CTRL_W-1:0] alu_control;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_ctrl,
        input  req1_valid, req1_op1, req1_op2, req1_ctrl,
        input  rsp0_ready, rsp1_ready, flush0, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_zero, alu_operand1, alu_operand2, alu_control
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_ctrl,
        output req1_valid, req1_op1, req1_op2, req1_ctrl,
        output rsp0_ready, rsp1_ready, flush0, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_zero, alu_operand1, alu_operand2, alu_control
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between the EX datapath (requester 0) and an auxiliary unit
// (requester 1). Two-entry pipeline: the issue register (s1) drives the ALU,
// the output register (out) holds the result until its owner takes it.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - alu_share_arbiter_if.slave (request/response handshakes, flush0,
//            ALU operand/control outputs and ALU result/zero inputs)
// Build option:
//   ALU_ARB_FIXED_PRIO_EN defined   -> requester 0 always wins ties
//   ALU_ARB_FIXED_PRIO_EN undefined -> round-robin between the requesters
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input logic                clk,
    input logic                reset,
    alu_share_arbiter_if.slave bus
);

    // issue stage
    logic              s1_valid_r;
    logic              s1_id_r;
    logic [DATA_W-1:0] s1_op1_r;
    logic [DATA_W-1:0] s1_op2_r;
    logic [CTRL_W-1:0] s1_ctrl_r;
    // output stage
    logic              out_valid_r;
    logic              out_id_r;
    logic [DATA_W-1:0] out_result_r;
    logic              out_zero_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant_r;
`endif

    logic out_drain_s;
    logic out_kill_s;
    logic out_free_s;
    logic s1_kill_s;
    logic s1_move_s;
    logic s1_free_s;
    logic elig0_s;
    logic grant_s;
    logic ready0_s;
    logic ready1_s;
    logic accept_s;

    // Pipeline advance conditions; a flushed requester-0 entry frees its slot
    // in the same cycle so requester 1 can be taken without a bubble.
    always_comb begin
        out_drain_s = 1'b0;
        out_kill_s  = 1'b0;
        s1_kill_s   = 1'b0;
        if (out_valid_r) begin
            out_drain_s = out_id_r ? bus.rsp1_ready : bus.rsp0_ready;
            out_kill_s  = !out_id_r && bus.flush0;
        end else begin
            out_drain_s = 1'b0;
            out_kill_s  = 1'b0;
        end
        if (s1_valid_r) begin
            s1_kill_s = !s1_id_r && bus.flush0;
        end else begin
            s1_kill_s = 1'b0;
        end
        out_free_s = !out_valid_r || out_drain_s || out_kill_s;
        // a killed s1 entry must never reach the output stage
        s1_move_s  = s1_valid_r && out_free_s && !s1_kill_s;
        s1_free_s  = !s1_valid_r || s1_move_s || s1_kill_s;
    end

    // Grant selection; requester 0 is ineligible while flush0 is high so a
    // waiting requester 1 is not locked out by a blocked tie.
    always_comb begin
        elig0_s = bus.req0_valid && !bus.flush0;
        grant_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (elig0_s) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
`else
        if (elig0_s && bus.req1_valid) begin
            grant_s = !last_grant_r;
        end else if (elig0_s) begin
            grant_s = 1'b0;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = !last_grant_r;
        end
`endif
        ready0_s = s1_free_s && !grant_s && !bus.flush0;
        ready1_s = s1_free_s && grant_s;
        accept_s = (ready0_s && bus.req0_valid) || (ready1_s && bus.req1_valid);
    end

    // Issue register: loads on acceptance, empties on move or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= 1'b0;
            s1_op1_r   <= {DATA_W{1'b0}};
            s1_op2_r   <= {DATA_W{1'b0}};
            s1_ctrl_r  <= {CTRL_W{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_id_r    <= grant_s;
            s1_op1_r   <= grant_s ? bus.req1_op1  : bus.req0_op1;
            s1_op2_r   <= grant_s ? bus.req1_op2  : bus.req0_op2;
            s1_ctrl_r  <= grant_s ? bus.req1_ctrl : bus.req0_ctrl;
        end else if (s1_move_s || s1_kill_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Output register: captures the ALU result as s1 advances, otherwise
    // holds every field stable until drained or flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_id_r     <= 1'b0;
            out_result_r <= {DATA_W{1'b0}};
            out_zero_r   <= 1'b0;
        end else if (s1_move_s) begin
            out_valid_r  <= 1'b1;
            out_id_r     <= s1_id_r;
            out_result_r <= bus.alu_result;
            out_zero_r   <= bus.alu_zero;
        end else if (out_drain_s || out_kill_s) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin history: moves only on a real transfer; reset value 1 hands
    // the first tie to requester 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            last_grant_r <= grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    assign bus.req0_ready   = ready0_s;
    assign bus.req1_ready   = ready1_s;
    assign bus.rsp0_valid   = out_valid_r && !out_id_r;
    assign bus.rsp1_valid   = out_valid_r && out_id_r;
    assign bus.rsp_result   = out_result_r;
    assign bus.rsp_zero     = out_zero_r;
    // ALU sees zeros whenever the issue slot is empty (including after flush)
    assign bus.alu_operand1 = s1_valid_r ? s1_op1_r  : {DATA_W{1'b0}};
    assign bus.alu_operand2 = s1_valid_r ? s1_op2_r  : {DATA_W{1'b0}};
    assign bus.alu_control  = s1_valid_r ? s1_ctrl_r : {CTRL_W{1'b0}};

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one arithmetic_logic_unit instance between two requesters.
  - Requester 0: EX-stage datapath.
  - Requester 1: auxiliary unit, e.g. address-gen/CSR helper.
- Round-robin arbitration, valid/ready request and response handshakes.
- Two-entry pipeline: issue register drives the ALU; response register holds the result until the owner accepts it.
- Sits beside EX; drives ALU operand/control ports and returns result plus zero flag.

Parameters:
- DATA_W, 32, operand/result width.
- CTRL_W, 4, ALU control width; passed through unmodified.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op1, req0_op2 / req1_op1, req1_op2  in  DATA_W  operands.
- req0_ctrl / req1_ctrl  in  CTRL_W  ALU control code (0000 ADD … 0101 SLT).
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester consumes result.
- rsp_result  out  DATA_W  registered ALU result (shared bus, qualified by rspN_valid).
- rsp_zero  out  1  registered zero flag.
- flush0  in  1  kill all in-flight requester-0 work (branch redirect).
- alu_operand1, alu_operand2  out  DATA_W  to ALU.
- alu_control  out  CTRL_W  to ALU.
- alu_result  in  DATA_W  from ALU.
- alu_zero  in  1  from ALU.

Behaviour:
- Reset is synchronous, active-high.
  - Outputs: s1_valid=0, out_valid=0, rsp*_valid=0, rsp_result=0, rsp_zero=0, alu_operand*/alu_control=0, last_grant=1, so requester 0 wins the first tie.
  - Reset mid-operation discards all in-flight entries; no response is emitted.
- Issue stage (s1): s1_valid, s1_id, s1_op1, s1_op2, s1_ctrl. ALU ports are driven directly from s1 registers, zeros when !s1_valid.
- Output stage (out): out_valid, out_id, rsp_result, rsp_zero. rspN_valid = out_valid && out_id==N.
- Advance conditions, all combinational:
  - out_free = !out_valid || rsp_ready[out_id].
  - s1_move = s1_valid && out_free.
  - s1_free = !s1_valid || s1_move.
- Grant:
  - Only one requester valid → grant it.
  - Both valid → grant !last_grant.
  - reqN_ready = s1_free && grant==N && !(N==0 && flush0).
- Ready depends on valids; requesters must not make valid depend on ready.
- Accept edge: s1 loads operands/ctrl/id; last_grant updates to the granted id. last_grant updates only on an actual transfer.
- s1_move edge: out loads alu_result, alu_zero, s1_id. Otherwise out holds all fields stable.
- Latency: accepted at edge E → rsp valid after edge E+1, given out free. Throughput is 1 op/cycle with no backpressure.
- Backpressure:
  - Response not accepted → out holds, s1 holds, ALU inputs stay constant, req*_ready=0.
  - Simultaneous out drain and s1 refill in the same cycle is required, no bubble.
- flush0 (same edge):
  - Clears s1_valid if s1_id==0.
  - Clears out_valid if out_id==0.
  - Blocks requester-0 acceptance.
  - Requester-1 entries are unaffected. Requester 1 may still be granted that cycle and must take the freed slot.
- Results are never reordered: strict FIFO through s1→out.
- ctrl codes are passed through unchanged. Undefined codes produce the ALU's 0 result and zero=1.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
  - Defined: requester 0 always wins ties; last_grant is unused and may be removed.
  - Undefined (default): round-robin as above.
- Reset, flush and handshake rules are identical in both builds.

Test Plan:
- Req0 ADD 5,7 (ctrl 0000), rsp0_ready=1 → rsp0_valid one cycle after accept, rsp_result=12, rsp_zero=0.
- Req1 SUB 9,9 (0001) → rsp1_valid, rsp_result=0, rsp_zero=1. Req1 SLT 3,8 (0101) → result 1.
- Both valid every cycle: req0 AND 0xF0,0x3C, req1 OR 0xF0,0x0F.
  - Round-robin build: grant sequence 0,1,0,1; results 0x30,0xFF alternating.
  - Fixed-prio build: req1 starved while req0 is valid.
- rsp0_ready=0 for 3 cycles with 2 ops accepted → req*_ready=0, rsp_result held constant, alu_operand* stable; on release both results appear in order on consecutive cycles.
- flush0 with s1 holding a req0 op and out holding a req1 result → req0 op never responds, req1 result still delivered, req1 accepted that same cycle.
- Reset asserted with s1 and out both valid → next cycle all rsp*_valid=0, ALU ports 0; first tie after reset granted to requester 0.
